// File: rtl/id_ex_register.sv
// -----------------------------------------------------------------------------
// id_ex_register
//
// The pipeline register between the ID and EX stages of the in-order core.
// It carries the decoded control bits and operand data into EX, and it
// handles the pipeline hazard controls:
//   - Stall holds every register, including the status outputs.
//   - Flush loads a bubble. Control bits and ValidOut are cleared, and the
//     data fields keep their values. Flush takes priority over Stall.
//   - If ValidIn is low on a normal load, the bubble enters with cleared
//     control bits, and the data fields are still captured.
// BubbleCount counts every bubble that enters EX after reset. It stops at
// 16'hFFFF instead of wrapping.
//
// Ports
//   clk, rst               rising-edge clock; synchronous active-high reset
//   Stall, Flush, ValidIn  pipeline control from the hazard unit / ID stage
//   Change .. RegWrite     control bits from the ID bubble mux
//   ReadData1/2, Immediate 32-bit operands (Immediate already sign-extended)
//   Rs, Rt, Rd             5-bit register specifiers
//   <name>_EX              registered copy of each control/data input
//   ValidOut               EX slot holds a real instruction
//   BubbleCount            number of bubbles inserted since reset (saturating)
//
// Every output comes straight from a flop. No input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module id_ex_register (
  input  logic        clk,
  input  logic        rst,

  input  logic        Stall,
  input  logic        Flush,
  input  logic        ValidIn,

  input  logic        Change,
  input  logic        ConstEnable,
  input  logic [3:0]  AluOp,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        RegWrite,

  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic [31:0] Immediate,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,

  output logic        Change_EX,
  output logic        ConstEnable_EX,
  output logic [3:0]  AluOp_EX,
  output logic        MemRead_EX,
  output logic        MemWrite_EX,
  output logic        MemToReg_EX,
  output logic        RegWrite_EX,

  output logic [31:0] ReadData1_EX,
  output logic [31:0] ReadData2_EX,
  output logic [31:0] Immediate_EX,
  output logic [4:0]  Rs_EX,
  output logic [4:0]  Rt_EX,
  output logic [4:0]  Rd_EX,

  output logic        ValidOut,
  output logic [15:0] BubbleCount
);

  logic        bubbleLoad;   // a bubble enters EX on this edge
  logic [15:0] bubbleNext;   // saturating increment of BubbleCount

  // NOTE: every combinational output gets a default before any condition.
  // A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    bubbleLoad = Flush | (~Stall & ~ValidIn);
    bubbleNext = BubbleCount;
    if (BubbleCount != 16'hFFFF) begin
      bubbleNext = BubbleCount + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples the values from before the edge, whatever the statement
  // order.
  always_ff @(posedge clk) begin
    if (rst) begin
      Change_EX      <= 1'b0;
      ConstEnable_EX <= 1'b0;
      AluOp_EX       <= 4'd0;
      MemRead_EX     <= 1'b0;
      MemWrite_EX    <= 1'b0;
      MemToReg_EX    <= 1'b0;
      RegWrite_EX    <= 1'b0;
      ReadData1_EX   <= 32'd0;
      ReadData2_EX   <= 32'd0;
      Immediate_EX   <= 32'd0;
      Rs_EX          <= 5'd0;
      Rt_EX          <= 5'd0;
      Rd_EX          <= 5'd0;
      ValidOut       <= 1'b0;
      BubbleCount    <= 16'd0;
    end else if (Flush) begin
      // Bubble: kill the control bits and leave the data fields as they are.
      Change_EX      <= 1'b0;
      ConstEnable_EX <= 1'b0;
      AluOp_EX       <= 4'd0;
      MemRead_EX     <= 1'b0;
      MemWrite_EX    <= 1'b0;
      MemToReg_EX    <= 1'b0;
      RegWrite_EX    <= 1'b0;
      ValidOut       <= 1'b0;
      BubbleCount    <= bubbleNext;
    end else if (!Stall) begin
      // An invalid slot gets its control bits gated here. A stray control
      // bit from ID therefore cannot write memory or the register file.
      Change_EX      <= Change      & ValidIn;
      ConstEnable_EX <= ConstEnable & ValidIn;
      AluOp_EX       <= AluOp & {4{ValidIn}};
      MemRead_EX     <= MemRead     & ValidIn;
      MemWrite_EX    <= MemWrite    & ValidIn;
      MemToReg_EX    <= MemToReg    & ValidIn;
      RegWrite_EX    <= RegWrite    & ValidIn;
      ReadData1_EX   <= ReadData1;
      ReadData2_EX   <= ReadData2;
      Immediate_EX   <= Immediate;
      Rs_EX          <= Rs;
      Rt_EX          <= Rt;
      Rd_EX          <= Rd;
      ValidOut       <= ValidIn;
      if (bubbleLoad) begin
        BubbleCount <= bubbleNext;
      end
    end
    // Stall without Flush: every register keeps its value.
  end

endmodule

// File: tb/tb_id_ex_register.sv
// -----------------------------------------------------------------------------
// tb_id_ex_register
//
// A directed bench for id_ex_register. Inputs change one time unit after
// each rising edge. Outputs are checked one time unit after the next rising
// edge. Every expected value is written out by hand.
// -----------------------------------------------------------------------------
module tb_id_ex_register;

  logic        clk;
  logic        rst;
  logic        Stall, Flush, ValidIn;
  logic        Change, ConstEnable, MemRead, MemWrite, MemToReg, RegWrite;
  logic [3:0]  AluOp;
  logic [31:0] ReadData1, ReadData2, Immediate;
  logic [4:0]  Rs, Rt, Rd;

  logic        Change_EX, ConstEnable_EX, MemRead_EX, MemWrite_EX;
  logic        MemToReg_EX, RegWrite_EX;
  logic [3:0]  AluOp_EX;
  logic [31:0] ReadData1_EX, ReadData2_EX, Immediate_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic        ValidOut;
  logic [15:0] BubbleCount;

  int total;
  int bad;

  id_ex_register dut (
    .clk(clk), .rst(rst),
    .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .Change(Change), .ConstEnable(ConstEnable), .AluOp(AluOp),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .RegWrite(RegWrite),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Immediate(Immediate),
    .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .Change_EX(Change_EX), .ConstEnable_EX(ConstEnable_EX),
    .AluOp_EX(AluOp_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .MemToReg_EX(MemToReg_EX),
    .RegWrite_EX(RegWrite_EX),
    .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
    .Immediate_EX(Immediate_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .ValidOut(ValidOut), .BubbleCount(BubbleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // A write-enable must never be high while the EX slot is empty.
  task automatic checkNoWriteWhenInvalid(input string tag);
    check({tag, "_memwr_gate"}, 32'(MemWrite_EX & ~ValidOut), 32'd0);
    check({tag, "_regwr_gate"}, 32'(RegWrite_EX & ~ValidOut), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setAll(input logic v);
    Stall = v; Flush = v; ValidIn = v;
    Change = v; ConstEnable = v; MemRead = v; MemWrite = v;
    MemToReg = v; RegWrite = v;
    AluOp = {4{v}};
    ReadData1 = {32{v}}; ReadData2 = {32{v}}; Immediate = {32{v}};
    Rs = {5{v}}; Rt = {5{v}}; Rd = {5{v}};
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset for two cycles with every other input driven high.
    rst = 1'b1;
    setAll(1'b1);
    tick();
    tick();
    check("rst_valid",   32'(ValidOut),     32'd0);
    check("rst_bubble",  32'(BubbleCount),  32'd0);
    check("rst_aluop",   32'(AluOp_EX),     32'd0);
    check("rst_regwr",   32'(RegWrite_EX),  32'd0);
    check("rst_memwr",   32'(MemWrite_EX),  32'd0);
    check("rst_rd1",     ReadData1_EX,      32'd0);
    check("rst_imm",     Immediate_EX,      32'd0);
    check("rst_rd",      32'(Rd_EX),        32'd0);

    // Normal load of a valid instruction.
    rst = 1'b0;
    setAll(1'b0);
    ValidIn = 1'b1; AluOp = 4'h6; RegWrite = 1'b1; ConstEnable = 1'b1;
    ReadData1 = 32'hDEADBEEF; ReadData2 = 32'h12345678;
    Immediate = 32'hFFFFFFF0; Rs = 5'd3; Rt = 5'd4; Rd = 5'd9;
    tick();
    check("load_aluop",  32'(AluOp_EX),       32'h6);
    check("load_regwr",  32'(RegWrite_EX),    32'd1);
    check("load_const",  32'(ConstEnable_EX), 32'd1);
    check("load_rd1",    ReadData1_EX,        32'hDEADBEEF);
    check("load_rd2",    ReadData2_EX,        32'h12345678);
    check("load_imm",    Immediate_EX,        32'hFFFFFFF0);
    check("load_rs",     32'(Rs_EX),          32'd3);
    check("load_rd",     32'(Rd_EX),          32'd9);
    check("load_valid",  32'(ValidOut),       32'd1);
    check("load_bubble", 32'(BubbleCount),    32'd0);

    // Stall for three cycles while the inputs change. ValidIn=0 under a
    // stall does not count as a bubble.
    Stall = 1'b1; ValidIn = 1'b0; AluOp = 4'h2; MemToReg = 1'b1;
    ReadData1 = 32'hCAFEF00D; Rd = 5'd17;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_aluop",  32'(AluOp_EX),    32'h6);
      check("stall_rd1",    ReadData1_EX,     32'hDEADBEEF);
      check("stall_rd",     32'(Rd_EX),       32'd9);
      check("stall_valid",  32'(ValidOut),    32'd1);
      check("stall_memtr",  32'(MemToReg_EX), 32'd0);
      check("stall_bubble", 32'(BubbleCount), 32'd0);
      ReadData1 = ReadData1 + 32'd1;
    end

    // Release the stall. The new values appear after the next edge.
    Stall = 1'b0; ValidIn = 1'b1; ReadData1 = 32'hCAFEF00D;
    tick();
    check("resume_aluop", 32'(AluOp_EX),    32'h2);
    check("resume_memtr", 32'(MemToReg_EX), 32'd1);
    check("resume_rd1",   ReadData1_EX,     32'hCAFEF00D);
    check("resume_rd",    32'(Rd_EX),       32'd17);
    check("resume_valid", 32'(ValidOut),    32'd1);

    // Flush and Stall together. Flush wins, and the data fields are held.
    Flush = 1'b1; Stall = 1'b1; MemWrite = 1'b1;
    ReadData1 = 32'h11111111; Rd = 5'd1;
    tick();
    check("flush_memwr",  32'(MemWrite_EX), 32'd0);
    check("flush_regwr",  32'(RegWrite_EX), 32'd0);
    check("flush_aluop",  32'(AluOp_EX),    32'd0);
    check("flush_memtr",  32'(MemToReg_EX), 32'd0);
    check("flush_valid",  32'(ValidOut),    32'd0);
    check("flush_bubble", 32'(BubbleCount), 32'd1);
    check("flush_rd1",    ReadData1_EX,     32'hCAFEF00D);
    check("flush_rd",     32'(Rd_EX),       32'd17);
    checkNoWriteWhenInvalid("flush");

    // An invalid slot on a normal load. Control bits are gated off and the
    // data is still captured.
    Flush = 1'b0; Stall = 1'b0; ValidIn = 1'b0;
    RegWrite = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
    ReadData2 = 32'hABCD0123;
    tick();
    check("inv_regwr",  32'(RegWrite_EX), 32'd0);
    check("inv_memrd",  32'(MemRead_EX),  32'd0);
    check("inv_memwr",  32'(MemWrite_EX), 32'd0);
    check("inv_valid",  32'(ValidOut),    32'd0);
    check("inv_bubble", 32'(BubbleCount), 32'd2);
    check("inv_rd2",    ReadData2_EX,     32'hABCD0123);
    check("inv_rd",     32'(Rd_EX),       32'd1);
    checkNoWriteWhenInvalid("inv");

    // Reset arriving during a stall and a flush overrides both.
    ValidIn = 1'b1; Stall = 1'b1; Flush = 1'b1; rst = 1'b1;
    tick();
    check("rstmid_bubble", 32'(BubbleCount), 32'd0);
    check("rstmid_rd2",    ReadData2_EX,     32'd0);
    check("rstmid_valid",  32'(ValidOut),    32'd0);

    // The first edge after reset is a normal load.
    rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; AluOp = 4'hA; Rd = 5'd31;
    tick();
    check("post_aluop",  32'(AluOp_EX),    32'hA);
    check("post_rd",     32'(Rd_EX),       32'd31);
    check("post_valid",  32'(ValidOut),    32'd1);
    check("post_regwr",  32'(RegWrite_EX), 32'd1);
    check("post_bubble", 32'(BubbleCount), 32'd0);

    // Saturation. 65535 flushes bring the count from 0 to the maximum.
    Flush = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    check("sat_reach", 32'(BubbleCount), 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_hold", 32'(BubbleCount), 32'h0000FFFF);
    end
    checkNoWriteWhenInvalid("sat");

    // A reset pulse clears the saturated count.
    rst = 1'b1;
    tick();
    check("sat_rst", 32'(BubbleCount), 32'd0);
    rst = 1'b0; Flush = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk is the single clock and rst is synchronous and active-high.
REQ-002 SHALL provide these clock and reset ports:
- clk  in  1  rising-edge clock.
- rst  in  1  sync reset.
REQ-003 SHALL provide these pipeline-control inputs:
- Stall  in  1  hold all state.
- Flush  in  1  load bubble.
- ValidIn  in  1  ID slot holds a real instruction.
REQ-004 SHALL provide these control inputs, taken from the ID-stage bubble mux output:
- Change  in  1.
- ConstEnable  in  1.
- AluOp  in  4.
- MemRead  in  1.
- MemWrite  in  1.
- MemToReg  in  1.
- RegWrite  in  1.
REQ-005 SHALL provide these data inputs:
- ReadData1  in  32.
- ReadData2  in  32.
- Immediate  in  32  sign-extended.
- Rs  in  5.
- Rt  in  5.
- Rd  in  5.
REQ-006 SHALL provide registered outputs named input name plus suffix _EX, with identical widths, for every control and data input listed in REQ-004 and REQ-005.
REQ-007 SHALL provide these status outputs:
- ValidOut  out  1  EX slot holds a real instruction.
- BubbleCount  out  16  bubbles inserted since reset.

Function
REQ-008 SHALL update all state only on the rising clk edge; all outputs SHALL be direct register outputs with no combinational path from any input.
REQ-009 SHALL evaluate priority per edge as: rst, then Flush, then Stall, then normal load.
REQ-010 On a normal load (Flush=0, Stall=0), SHALL capture every input into its _EX register and set ValidOut=ValidIn, with 1-cycle latency.
REQ-011 On a normal load with ValidIn=0, SHALL force all control _EX outputs to 0 and capture data fields normally.
REQ-012 On Stall=1 with Flush=0, SHALL hold every register, including ValidOut and BubbleCount, unchanged.
REQ-013 On Flush=1, SHALL clear all control _EX outputs and ValidOut to 0 regardless of Stall, while holding data fields.
REQ-014 SHALL increment BubbleCount by 1 on each edge where a bubble is loaded: Flush=1, or (Stall=0 and ValidIn=0).
REQ-015 SHALL saturate BubbleCount at 16'hFFFF with no wrap to 0.
REQ-016 SHALL never raise MemWrite_EX or RegWrite_EX while ValidOut=0.
REQ-017 With Stall held for N cycles, SHALL present identical outputs for those N cycles and resume loading on the first edge with Stall=0.

Reset
REQ-018 On rst=1 at a clk edge, SHALL clear every _EX output, ValidOut and BubbleCount to 0, overriding Flush and Stall.
REQ-019 Reset asserted mid-stall or mid-flush SHALL take effect on that edge, and the first edge after rst deasserts SHALL be treated as a normal priority evaluation.
REQ-020 SHALL give all outputs a defined value (0) from the first reset edge onward.

Verification
REQ-021 Reset: rst=1 for 2 cycles with all inputs =1 -> all outputs 0 and BubbleCount=0.
REQ-022 Load: ValidIn=1, AluOp=4'h6, RegWrite=1, ReadData1=32'hDEADBEEF, Rd=5'd9 -> next edge AluOp_EX=6, RegWrite_EX=1, ReadData1_EX=32'hDEADBEEF, Rd_EX=9, ValidOut=1.
REQ-023 Stall: after REQ-022, Stall=1 for 3 cycles while inputs change -> outputs unchanged and BubbleCount unchanged; Stall=0 -> new values on the next edge.
REQ-024 Flush with Stall: Flush=1 and Stall=1, MemWrite=1 -> control outputs=0, ValidOut=0, BubbleCount +1, data fields held.
REQ-025 Invalid slot: ValidIn=0, RegWrite=1, MemRead=1 -> RegWrite_EX=0, MemRead_EX=0, ValidOut=0, BubbleCount +1.
REQ-026 Saturation: BubbleCount preloaded near max via 65535 Flush cycles, then 5 more Flush cycles -> BubbleCount stays 16'hFFFF; a following rst pulse -> 0.
